// File: rtl/seg7_pkg.sv
// Shared constants for the scanned seven-segment driver: segment patterns
// (active low, {g,f,e,d,c,b,a}), scan state encoding and anode helpers.
package seg7_pkg;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_B     = 7'b0000011;
    localparam logic [6:0] SEG_C     = 7'b1000110;
    localparam logic [6:0] SEG_D     = 7'b0100001;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_F     = 7'b0001110;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic {
        ST_GUARD = 1'b0,
        ST_SHOW  = 1'b1
    } state_t;

    localparam int AN_MAX = 8;

    function automatic logic [AN_MAX-1:0] an_off();
        return '1;
    endfunction

    // Active-low one-cold anode vector for digit idx.
    function automatic logic [AN_MAX-1:0] an_select(input logic [2:0] idx);
        return ~(8'b1 << idx);
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational 4-bit code to seven-segment decoder; decimal mode darkens 10-15.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] code,
    input  logic       hex_mode,
    input  logic       blank,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (!blank) begin
            case (code)
                4'h0: seg = SEG_0;
                4'h1: seg = SEG_1;
                4'h2: seg = SEG_2;
                4'h3: seg = SEG_3;
                4'h4: seg = SEG_4;
                4'h5: seg = SEG_5;
                4'h6: seg = SEG_6;
                4'h7: seg = SEG_7;
                4'h8: seg = SEG_8;
                4'h9: seg = SEG_9;
                4'hA: seg = hex_mode ? SEG_A : SEG_BLANK;
                4'hB: seg = hex_mode ? SEG_B : SEG_BLANK;
                4'hC: seg = hex_mode ? SEG_C : SEG_BLANK;
                4'hD: seg = hex_mode ? SEG_D : SEG_BLANK;
                4'hE: seg = hex_mode ? SEG_E : SEG_BLANK;
                4'hF: seg = hex_mode ? SEG_F : SEG_BLANK;
                default: seg = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/seg7_scan_mux.sv
// Scanned N-digit common-anode driver with a shadow digit image, dead-time
// guard between digits and optional leading-zero suppression.
module seg7_scan_mux
    import seg7_pkg::*;
#(
    parameter int N_DIGITS  = 8,
    parameter int SCAN_DIV  = 50000,
    parameter int GUARD_CYC = 500
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [4*N_DIGITS-1:0] digit_in,
    input  logic [N_DIGITS-1:0]   blank_in,
    input  logic [N_DIGITS-1:0]   dp_in,
    input  logic                  hex_mode,
    input  logic                  lzs,
    output logic [6:0]            HEX0,
    output logic                  DP,
    output logic [N_DIGITS-1:0]   AN
);

    localparam int CNT_MAX = (SCAN_DIV > GUARD_CYC) ? SCAN_DIV : GUARD_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int IDX_W   = $clog2(N_DIGITS);

    localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'((GUARD_CYC > 0) ? GUARD_CYC - 1 : 0);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(N_DIGITS - 1);

    logic [4*N_DIGITS-1:0] digit_sh;
    logic [N_DIGITS-1:0]   blank_sh;
    logic [N_DIGITS-1:0]   dp_sh;

    state_t            state, state_nx;
    logic [CNT_W-1:0]  cnt, cnt_nx;
    logic [IDX_W-1:0]  idx, idx_nx;

    logic [N_DIGITS-1:0] lz_mask;
    logic [3:0]          code_sel;
    logic                blank_sel;
    logic [6:0]          seg_sel;

    // Walk down from the most significant digit; a blanked digit reads as zero.
    always_comb begin
        logic all_zero;
        all_zero = 1'b1;
        lz_mask  = '0;
        for (int k = N_DIGITS - 1; k >= 1; k--) begin
            all_zero   = all_zero & (blank_sh[k] | (digit_sh[4*k +: 4] == 4'd0));
            lz_mask[k] = lzs & all_zero;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt + 1'b1;
        idx_nx   = idx;
        if (state == ST_GUARD) begin
            if (GUARD_CYC == 0 || cnt == GUARD_LAST) begin
                state_nx = ST_SHOW;
                cnt_nx   = '0;
            end
        end else if (cnt == SHOW_LAST) begin
            idx_nx   = (idx == IDX_LAST) ? '0 : idx + 1'b1;
            cnt_nx   = '0;
            state_nx = (GUARD_CYC == 0) ? ST_SHOW : ST_GUARD;
        end
    end

    // Decode the digit that will be lit after this edge so outputs stay aligned with AN.
    assign code_sel  = digit_sh[4*idx_nx +: 4];
    assign blank_sel = blank_sh[idx_nx] | lz_mask[idx_nx];

    seg7_decode u_decode (
        .code     (code_sel),
        .hex_mode (hex_mode),
        .blank    (blank_sel),
        .seg      (seg_sel)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digit_sh <= '0;
            blank_sh <= '0;
            dp_sh    <= '0;
            state    <= ST_GUARD;
            cnt      <= '0;
            idx      <= '0;
            AN       <= N_DIGITS'(an_off());
            HEX0     <= SEG_BLANK;
            DP       <= 1'b1;
        end else begin
            if (load) begin
                digit_sh <= digit_in;
                blank_sh <= blank_in;
                dp_sh    <= dp_in;
            end
            state <= state_nx;
            cnt   <= cnt_nx;
            idx   <= idx_nx;
            if (state_nx == ST_SHOW) begin
                AN   <= N_DIGITS'(an_select(3'(idx_nx)));
                HEX0 <= seg_sel;
                DP   <= ~dp_sh[idx_nx];
            end else begin
                AN   <= N_DIGITS'(an_off());
                HEX0 <= SEG_BLANK;
                DP   <= 1'b1;
            end
        end
    end

endmodule

// File: doc/seg7_scan_mux.md
Name: seg7_scan_mux

Overview:
Time-multiplexed driver for a bank of common-anode seven-segment digits on the lab board. It holds a double-buffered digit image of 4-bit codes with per-digit blank and decimal-point bits. It scans one digit at a time with a dead-time guard between digits. Each code decodes in decimal mode (0-9, 10-15 blank) or hex mode (0-F); leading-zero suppression is optional. It replaces the single static digit drive (fixed AN, one decoder) with a scanned N-digit display.

Parameters:
N_DIGITS, 8, number of digits / anode lines (2..8)
SCAN_DIV, 50000, clock cycles each digit is lit (SHOW phase, >=1)
GUARD_CYC, 500, cycles with all anodes off between digits (0 = no guard phase)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
load  input  1  strobe: capture digit_in/blank_in/dp_in into shadow image
digit_in  input  4*N_DIGITS  digit codes, digit k at [4k+3:4k], digit 0 rightmost
blank_in  input  N_DIGITS  1 = force digit k dark
dp_in  input  N_DIGITS  1 = light decimal point of digit k
hex_mode  input  1  0 = decimal (10-15 blank), 1 = hex A-F
lzs  input  1  1 = suppress leading zeros
HEX0  output  7  segments {g,f,e,d,c,b,a}, active low
DP  output  1  decimal point, active low
AN  output  N_DIGITS  anode enables, active low, at most one low at any time

Behaviour:
- Reset is asynchronous on rst_n low. Shadow image is cleared to 0. digit index = 0, cycle counter = 0, state = GUARD. AN = all ones, HEX0 = 7'b1111111, DP = 1.
- All outputs are registered. AN, HEX0 and DP update on the same edge.
- load = 1 at edge k: shadow takes the inputs at edge k. The new value drives the outputs from edge k+1 if the digit is in SHOW. Without load, shadow holds. Inputs are sampled only on load.
- FSM, two states:
  - GUARD: AN all ones, HEX0 all ones, DP = 1. Lasts GUARD_CYC cycles, then SHOW for the current index. If GUARD_CYC = 0, GUARD is skipped entirely; after reset the first SHOW starts on the first edge.
  - SHOW: AN[idx] = 0 with all other bits 1. HEX0 and DP are re-registered every cycle from shadow[idx]. Lasts SCAN_DIV cycles. At the end, idx = (idx == N_DIGITS-1) ? 0 : idx+1, then GUARD (or SHOW directly if GUARD_CYC = 0).
- One full frame = N_DIGITS*(SCAN_DIV+GUARD_CYC) cycles. The counter width is clog2(max(SCAN_DIV,GUARD_CYC)+1). The counter resets to 0 on every state change.
- Decode patterns:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - hex_mode = 1: A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110
  - hex_mode = 0: codes 10-15 give 1111111
- Blank precedence:
  - blank_in[k] = 1 forces HEX0 = 1111111 but does not affect DP; dp_in[k] still lights the point.
  - With lzs = 1, digit k is suppressed (HEX0 all ones) if k > 0 and every code from digit N_DIGITS-1 down to k is 0.
  - Blanked digits count as zero for this scan.
  - Digit 0 is never zero-suppressed.
  - DP of a suppressed digit still follows dp_in.
- hex_mode and lzs are live inputs, evaluated each SHOW cycle and not latched by load.
- Reset asserted mid-SHOW: AN goes all ones immediately (asynchronously). On release, scanning restarts in GUARD at digit 0.

Decomposition:
- Shared package seg7_pkg holds:
  - the 16 segment-pattern constants plus SEG_BLANK = 7'b1111111
  - the state encoding (ST_GUARD, ST_SHOW)
  - the anode-off constant helper
- One combinational sub-module, seg7_decode (code[3:0], hex_mode, blank → seg[6:0]), instantiated once on the selected digit.
- Leading-zero mask logic and the FSM live in seg7_scan_mux.

Test Plan:
All cases use N_DIGITS=4, SCAN_DIV=4, GUARD_CYC=1 unless stated.
1. Reset: hold rst_n = 0 for 3 cycles, then release → AN=4'b1111, HEX0=1111111, DP=1 during reset and for 1 cycle after. Then AN=4'b1110 for exactly 4 cycles, AN=1111 for 1 cycle, then AN=1101. Period is 20 cycles.
2. Load digit_in=16'h1234, blank_in=0, dp_in=4'b0100, hex_mode=0 → while AN=1110 HEX0=0011001 (4). While AN=1011 HEX0=0100100 (2) and DP=0; DP=1 on the other digits.
3. Load 16'h00A5, hex_mode toggled 0→1 → digit 1 (code A) reads 1111111 when hex_mode=0 and 0001000 when hex_mode=1, changing the cycle after the toggle within the same SHOW.
4. Load 16'h0050 with lzs=1 → digits 3 and 2 read 1111111, digit 1 reads 0010010, digit 0 reads 1000000. Load 16'h0000 with lzs=1 → only digit 0 shows 1000000.
5. Pulse load with 16'hFFFF while digit 2 is in SHOW (old image 16'h1234) → HEX0 changes from 0100100 to blank/F per hex_mode on the edge after load. AN is unchanged and the scan timing is unaffected.
6. GUARD_CYC=0, reset pulsed low mid-SHOW of digit 3 → AN=1111 asynchronously. After release, AN=1110 on the first edge with no guard gap, and AN never shows two zeros at once.
